// File: rtl/ltc2308_pkg.sv
// Shared definitions for the LTC2308 SPI responder: config bit positions,
// FSM encoding and the single-ended channel map.
package ltc2308_pkg;

   localparam int DATA_W = 12;
   localparam int CFG_W  = 6;

   // Config word layout {S/D, O/S, S1, S0, UNI, SLP}
   localparam int CFG_SD  = 5;
   localparam int CFG_OS  = 4;
   localparam int CFG_S1  = 3;
   localparam int CFG_S0  = 2;
   localparam int CFG_UNI = 1;
   localparam int CFG_SLP = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_READY   = 2'd2,
      ST_SHIFT   = 2'd3
   } ltc_state_t;

   // Channel number as reported in the result word: {S1, S0, O/S}
   function automatic logic [2:0] ltc_channel(input logic [CFG_W-1:0] cfg);
      return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
   endfunction

endpackage

// File: rtl/ltc2308_emulator_if.sv
// Four-wire ADC link. The master (capture logic) owns convst/sck/sdi and the
// device answers on sdo; all lines are plain levels sampled by the device.
interface ltc2308_emulator_if;

   logic adc_convst;
   logic adc_sck;
   logic adc_sdi;
   logic adc_sdo;

   modport master (output adc_convst, output adc_sck, output adc_sdi, input adc_sdo);
   modport slave  (input adc_convst, input adc_sck, input adc_sdi, output adc_sdo);

endinterface

// File: rtl/ltc2308_emulator_sync_edge_detect.sv
// Optional synchroniser chain followed by a one-cycle rise/fall pulse generator.
// STAGES = 0 passes the input straight through for a same-clock master.
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic prev;

   generate
      if (STAGES == 0) begin : g_direct
         assign q = d;
      end else begin : g_sync
         logic [STAGES-1:0] chain;
         always_ff @(posedge clk) begin
            if (reset) begin
               chain <= '0;
            end else begin
               chain[0] <= d;
               for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            end
         end
         assign q = chain[STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) prev <= 1'b0;
      else       prev <= q;
   end

   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/ltc2308_emulator.sv
// LTC2308 device-side emulator: oversamples the master's CONVST/SCK, returns
// {channel, count} per conversion and latches the config shifted in on SDI.
module ltc2308_emulator
   import ltc2308_pkg::*;
#(
   parameter int               SYNC_STAGES   = 2,
   parameter int               T_CONV_CYCLES = 256,
   parameter logic [CFG_W-1:0] CFG_RESET     = 6'b100010
) (
   input  logic                 clk,
   input  logic                 reset,
   ltc2308_emulator_if.slave    adc,
   output logic [CFG_W-1:0]     cfg_word,
   output logic [15:0]          conv_count,
   output logic                 busy,
   output logic                 protocol_err,
   output ltc_state_t           state_dbg
);

   localparam int CNT_W = (T_CONV_CYCLES > 1) ? $clog2(T_CONV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(T_CONV_CYCLES - 1);

   logic cv_q, cv_rise, cv_fall;
   logic sck_level_unused, sck_rise, sck_fall;
   logic sdi_q;

   ltc_state_t         state;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  data_q;
   logic [DATA_W-1:0]  new_data;
   logic [3:0]         bit_idx;
   logic [3:0]         idx_dn;
   logic [2:0]         rise_cnt;
   logic [CFG_W-1:0]   shreg;
   logic [CFG_W-1:0]   active_cfg;
   logic               sdo_q;

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_convst (
      .clk(clk), .reset(reset), .d(adc.adc_convst),
      .q(cv_q), .rise(cv_rise), .fall(cv_fall)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sck (
      .clk(clk), .reset(reset), .d(adc.adc_sck),
      .q(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
   );

   // SDI only needs the same delay as SCK so it is aligned at the detected rise
   generate
      if (SYNC_STAGES == 0) begin : g_sdi_direct
         assign sdi_q = adc.adc_sdi;
      end else begin : g_sdi_sync
         logic [SYNC_STAGES-1:0] sdi_chain;
         always_ff @(posedge clk) begin
            if (reset) begin
               sdi_chain <= '0;
            end else begin
               sdi_chain[0] <= adc.adc_sdi;
               for (int i = 1; i < SYNC_STAGES; i++) sdi_chain[i] <= sdi_chain[i-1];
            end
         end
         assign sdi_q = sdi_chain[SYNC_STAGES-1];
      end
   endgenerate

   assign new_data = {ltc_channel(active_cfg), conv_count[8:0]};
   assign idx_dn   = bit_idx - 4'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         data_q       <= '0;
         bit_idx      <= '0;
         rise_cnt     <= '0;
         shreg        <= '0;
         active_cfg   <= CFG_RESET;
         cfg_word     <= CFG_RESET;
         conv_count   <= '0;
         sdo_q        <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cv_rise) begin
                  state      <= ST_CONVERT;
                  cnt        <= CNT_LOAD;
                  active_cfg <= cfg_word;
               end
            end
            ST_CONVERT: begin
               if (sck_rise || sck_fall) protocol_err <= 1'b1;
               if (cnt == '0) begin
                  data_q     <= new_data;
                  conv_count <= conv_count + 16'd1;
                  if (cv_q) begin
                     state <= ST_READY;
                  end else begin
                     state    <= ST_SHIFT;
                     sdo_q    <= new_data[DATA_W-1];
                     bit_idx  <= 4'(DATA_W - 1);
                     rise_cnt <= '0;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_READY: begin
               if (cv_fall) begin
                  state    <= ST_SHIFT;
                  sdo_q    <= data_q[DATA_W-1];
                  bit_idx  <= 4'(DATA_W - 1);
                  rise_cnt <= '0;
               end
            end
            ST_SHIFT: begin
               // A new CONVST here means the master abandoned the read
               if (cv_rise) begin
                  protocol_err <= 1'b1;
                  state        <= ST_CONVERT;
                  cnt          <= CNT_LOAD;
                  active_cfg   <= cfg_word;
                  sdo_q        <= 1'b0;
               end else if (sck_fall) begin
                  if (bit_idx == 4'd0) begin
                     sdo_q <= 1'b0;
                     state <= ST_IDLE;
                     if (rise_cnt == 3'(CFG_W)) cfg_word <= shreg;
                     else                       protocol_err <= 1'b1;
                  end else begin
                     bit_idx <= idx_dn;
                     sdo_q   <= data_q[idx_dn];
                  end
               end else if (sck_rise && rise_cnt != 3'(CFG_W)) begin
                  shreg    <= {shreg[CFG_W-2:0], sdi_q};
                  rise_cnt <= rise_cnt + 3'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign adc.adc_sdo = sdo_q;
   assign busy        = (state == ST_CONVERT);
   assign state_dbg   = state;

endmodule

// File: tb/tb_ltc2308_emulator.sv
// Bench for ltc2308_emulator: table of full transfers plus hand sequences for
// READY timing, SCK during conversion, reset mid-read and an aborted read.
module tb_ltc2308_emulator;
   import ltc2308_pkg::*;

   localparam int SYNC  = 2;
   localparam int TCONV = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  cfg_word;
   logic [15:0] conv_count;
   logic        busy;
   logic        protocol_err;
   ltc_state_t  state_dbg;

   ltc2308_emulator_if bus();

   ltc2308_emulator #(
      .SYNC_STAGES(SYNC), .T_CONV_CYCLES(TCONV), .CFG_RESET(6'b100010)
   ) dut (
      .clk(clk), .reset(reset), .adc(bus),
      .cfg_word(cfg_word), .conv_count(conv_count), .busy(busy),
      .protocol_err(protocol_err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [11:0] exp_q[$];
   logic [5:0]  m_cfg;
   logic [15:0] m_cnt;

   typedef struct {
      logic [5:0]  sdi_cfg;
      logic [11:0] exp_word;
      logic [15:0] exp_count;
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] model_word(input logic [5:0] c, input logic [15:0] n);
      return {c[3], c[2], c[4], n[8:0]};
   endfunction

   task automatic wait_state(input ltc_state_t st, input string name, output int n);
      n = 0;
      while (state_dbg != st && n < 2000) begin
         tick();
         n++;
      end
      if (state_dbg != st) check({name, " timeout"}, 32'(state_dbg), 32'(st));
   endtask

   task automatic start_conv(input bit hold);
      tick();
      bus.adc_convst = 1'b1;
      tick();
      tick();
      if (!hold) bus.adc_convst = 1'b0;
   endtask

   // SCK at clk/8; sdo sampled at each rise, sdi presented MSB first
   task automatic read_word(input logic [5:0] cfg_in, input int nfalls, output logic [11:0] w);
      w = '0;
      for (int k = 0; k < nfalls; k++) begin
         bus.adc_sdi = (k < 6) ? cfg_in[5-k] : 1'b0;
         repeat (4) tick();
         w = {w[10:0], bus.adc_sdo};
         bus.adc_sck = 1'b1;
         repeat (4) tick();
         bus.adc_sck = 1'b0;
      end
      bus.adc_sdi = 1'b0;
      repeat (8) tick();
   endtask

   task automatic sb_compare(input string name, input logic [11:0] w);
      logic [11:0] e;
      if (exp_q.size() == 0) begin
         check({name, " queue empty"}, 32'(w), 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         check(name, 32'(w), 32'(e));
      end
   endtask

   task automatic full_conversion(input logic [5:0] sdi_cfg, input string name);
      logic [11:0] w;
      int n;
      exp_q.push_back(model_word(m_cfg, m_cnt));
      start_conv(1'b0);
      wait_state(ST_SHIFT, {name, " shift"}, n);
      repeat (4) tick();
      read_word(sdi_cfg, 12, w);
      sb_compare({name, " word"}, w);
      m_cfg = sdi_cfg;
      m_cnt++;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1);
   end

   initial begin
      logic [11:0] w;
      logic [11:0] e;
      int n;

      tbl[0] = '{sdi_cfg: 6'b110010, exp_word: 12'h000, exp_count: 16'd1};
      tbl[1] = '{sdi_cfg: 6'b101110, exp_word: 12'h201, exp_count: 16'd2};
      tbl[2] = '{sdi_cfg: 6'b011101, exp_word: 12'hC02, exp_count: 16'd3};
      tbl[3] = '{sdi_cfg: 6'b111010, exp_word: 12'hE03, exp_count: 16'd4};
      tbl[4] = '{sdi_cfg: 6'b100010, exp_word: 12'hA04, exp_count: 16'd5};
      tbl[5] = '{sdi_cfg: 6'b001100, exp_word: 12'h005, exp_count: 16'd6};

      reset = 1'b1;
      bus.adc_convst = 1'b0;
      bus.adc_sck    = 1'b0;
      bus.adc_sdi    = 1'b0;
      repeat (3) tick();
      check("reset state", 32'(state_dbg), 32'(ST_IDLE));
      check("reset sdo", 32'(bus.adc_sdo), 32'd0);
      check("reset cfg_word", 32'(cfg_word), 32'b100010);
      check("reset conv_count", 32'(conv_count), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset protocol_err", 32'(protocol_err), 32'd0);
      reset = 1'b0;
      tick();
      m_cfg = 6'b100010;
      m_cnt = 16'd0;

      // Table of complete transfers: config from transfer N shows in word N+1
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(tbl[i].exp_word);
         start_conv(1'b0);
         wait_state(ST_SHIFT, $sformatf("vec%0d shift", i), n);
         repeat (4) tick();
         read_word(tbl[i].sdi_cfg, 12, w);
         sb_compare($sformatf("vec%0d word", i), w);
         check($sformatf("vec%0d cfg_word", i), 32'(cfg_word), 32'(tbl[i].sdi_cfg));
         check($sformatf("vec%0d conv_count", i), 32'(conv_count), 32'(tbl[i].exp_count));
         check($sformatf("vec%0d protocol_err", i), 32'(protocol_err), 32'd0);
         m_cfg = tbl[i].sdi_cfg;
         m_cnt = tbl[i].exp_count;
      end

      // CONVST held past done: READY timing, then first bit after the fall
      e = model_word(m_cfg, m_cnt);
      exp_q.push_back(e);
      tick();
      bus.adc_convst = 1'b1;
      wait_state(ST_READY, "hold ready", n);
      check("hold ready latency", 32'(n), 32'(TCONV + SYNC + 1));
      check("hold ready busy", 32'(busy), 32'd0);
      tick();
      bus.adc_convst = 1'b0;
      wait_state(ST_SHIFT, "hold shift", n);
      check("hold shift latency", 32'(n), 32'(SYNC + 1));
      check("hold first sdo bit", 32'(bus.adc_sdo), 32'(e[11]));
      repeat (4) tick();
      read_word(6'b100010, 12, w);
      sb_compare("hold word", w);
      m_cfg = 6'b100010;
      m_cnt++;
      check("hold cfg_word", 32'(cfg_word), 32'(m_cfg));

      // SCK toggled while converting: flagged but the conversion completes
      exp_q.push_back(model_word(m_cfg, m_cnt));
      start_conv(1'b0);
      wait_state(ST_CONVERT, "sckconv convert", n);
      repeat (2) begin
         bus.adc_sck = 1'b1;
         repeat (4) tick();
         bus.adc_sck = 1'b0;
         repeat (4) tick();
      end
      check("sckconv protocol_err", 32'(protocol_err), 32'd1);
      check("sckconv busy", 32'(busy), 32'd1);
      wait_state(ST_SHIFT, "sckconv shift", n);
      repeat (4) tick();
      read_word(6'b111111, 12, w);
      sb_compare("sckconv word", w);
      m_cfg = 6'b111111;
      m_cnt++;
      check("sckconv conv_count", 32'(conv_count), 32'(m_cnt));

      // Reset in the middle of a read
      start_conv(1'b0);
      wait_state(ST_SHIFT, "midreset shift", n);
      repeat (4) tick();
      read_word(6'b010101, 5, w);
      check("midreset pre state", 32'(state_dbg), 32'(ST_SHIFT));
      reset = 1'b1;
      tick();
      check("midreset sdo", 32'(bus.adc_sdo), 32'd0);
      check("midreset state", 32'(state_dbg), 32'(ST_IDLE));
      check("midreset cfg_word", 32'(cfg_word), 32'b100010);
      check("midreset conv_count", 32'(conv_count), 32'd0);
      check("midreset protocol_err", 32'(protocol_err), 32'd0);
      reset = 1'b0;
      tick();
      m_cfg = 6'b100010;
      m_cnt = 16'd0;

      // Aborted read: CONVST rises after 4 SCK falls
      full_conversion(6'b110010, "abort setup");
      start_conv(1'b0);
      wait_state(ST_SHIFT, "abort shift", n);
      m_cnt++;
      repeat (4) tick();
      read_word(6'b001111, 4, w);
      bus.adc_convst = 1'b1;
      repeat (SYNC + 1) tick();
      check("abort busy", 32'(busy), 32'd1);
      check("abort protocol_err", 32'(protocol_err), 32'd1);
      check("abort cfg_word", 32'(cfg_word), 32'b110010);
      bus.adc_convst = 1'b0;
      exp_q.push_back(model_word(m_cfg, m_cnt));
      wait_state(ST_SHIFT, "abort resume shift", n);
      repeat (4) tick();
      read_word(6'b000000, 12, w);
      sb_compare("abort resume word", w);
      m_cnt++;
      check("abort resume cfg_word", 32'(cfg_word), 32'd0);
      check("abort resume conv_count", 32'(conv_count), 32'(m_cnt));
      check("abort idle sdo", 32'(bus.adc_sdo), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
